sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags.sv | 163 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// sync_fifo_flags
// Parametrised single-clock FIFO with registered or first-word-fall-through
// read, programmable almost-full/almost-empty thresholds, an occupancy count
// and sticky overflow/underflow error flags.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   wren_i      : write request
//   wdata_i     : write data
//   rden_i      : read request (a pop in FWFT mode)
//   clr_err_i   : synchronous clear of the sticky error flags
//   rdata_o     : read data
//   full_o      : count == FIFO_DEPTH
//   empty_o     : count == 0
//   afull_o     : count >= AF_LEVEL
//   aempty_o    : count <= AE_LEVEL
//   count_o     : current occupancy, 0..FIFO_DEPTH
//   overflow_o  : sticky, a write was rejected
//   underflow_o : sticky, a read was rejected
// ----------------------------------------------------------------------------
module sync_fifo_flags #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int unsigned AE_LEVEL   = 2,
   parameter bit          FWFT       = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wren_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   input  logic                        rden_i,
   input  logic                        clr_err_i,
   output logic [DATA_WIDTH-1:0]       rdata_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic                        afull_o,
   output logic                        aempty_o,
   output logic [$clog2(FIFO_DEPTH):0] count_o,
   output logic                        overflow_o,
   output logic                        underflow_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          r_underflow;

   logic [AW:0]   w_wptr_d;
   logic [AW:0]   w_rptr_d;
   logic [AW:0]   w_count_d;
   logic          w_overflow_d;
   logic          w_underflow_d;
   logic          w_full;
   logic          w_empty;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic [AW-1:0] w_waddr;
   logic [AW-1:0] w_raddr;

   // Flags come only from the registered count, so they act as registered flags.
   always_comb begin
      w_full   = (r_count == DEPTH_CNT);
      w_empty  = (r_count == '0);
      w_wr_acc = wren_i && !w_full;
      w_rd_acc = rden_i && !w_empty;
      w_waddr  = r_wptr[AW-1:0];
      w_raddr  = r_rptr[AW-1:0];
   end

   always_comb begin
      w_wptr_d = r_wptr;
      w_rptr_d = r_rptr;
      if (w_wr_acc) begin
         w_wptr_d = r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
         w_rptr_d = r_rptr + 1'b1;
      end
      // Pointer difference modulo 2^(AW+1); the wrap bit separates full from empty.
      w_count_d = w_wptr_d - w_rptr_d;
   end

   // Set wins over a simultaneous clear.
   always_comb begin
      w_overflow_d  = r_overflow;
      w_underflow_d = r_underflow;
      if (clr_err_i) begin
         w_overflow_d  = 1'b0;
         w_underflow_d = 1'b0;
      end
      if (wren_i && w_full) begin
         w_overflow_d = 1'b1;
      end
      if (rden_i && w_empty) begin
         w_underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wptr      <= w_wptr_d;
         r_rptr      <= w_rptr_d;
         r_count     <= w_count_d;
         r_overflow  <= w_overflow_d;
         r_underflow <= w_underflow_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[w_waddr] <= wdata_i;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word shown combinationally; meaningless while empty.
         assign rdata_o = r_mem[w_raddr];
      end else begin : g_reg_read
         logic [DATA_WIDTH-1:0] r_rdata;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rdata <= '0;
            end else if (w_rd_acc) begin
               r_rdata <= r_mem[w_raddr];
            end
         end

         assign rdata_o = r_rdata;
      end
   endgenerate

   always_comb begin
      full_o      = w_full;
      empty_o     = w_empty;
      afull_o     = (r_count >= AF_CNT);
      aempty_o    = (r_count <= AE_CNT);
      count_o     = r_count;
      overflow_o  = r_overflow;
      underflow_o = r_underflow;
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Drives one registered-read and one FWFT instance of sync_fifo_flags with the
// same stimulus and checks both against a queue-based model every cycle, plus
// directed sequences with literal expectations.
// ----------------------------------------------------------------------------
module tb_sync_fifo_flags;

   localparam int DEPTH = 8;

   logic       clk;
   logic       rst_n;
   logic       wren;
   logic [7:0] wdata;
   logic       rden;
   logic       clr_err;

   logic [7:0] rdata0, rdata1;
   logic       full0, full1, empty0, empty1, afull0, afull1, aempty0, aempty1;
   logic [3:0] count0, count1;
   logic       ovf0, ovf1, ufl0, ufl1;

   int checks = 0;
   int errors = 0;

   sync_fifo_flags #(
      .DATA_WIDTH (8),
      .FIFO_DEPTH (DEPTH),
      .AF_LEVEL   (6),
      .AE_LEVEL   (2),
      .FWFT       (1'b0)
   ) u_dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .wren_i      (wren),
      .wdata_i     (wdata),
      .rden_i      (rden),
      .clr_err_i   (clr_err),
      .rdata_o     (rdata0),
      .full_o      (full0),
      .empty_o     (empty0),
      .afull_o     (afull0),
      .aempty_o    (aempty0),
      .count_o     (count0),
      .overflow_o  (ovf0),
      .underflow_o (ufl0)
   );

   sync_fifo_flags #(
      .DATA_WIDTH (8),
      .FIFO_DEPTH (DEPTH),
      .AF_LEVEL   (6),
      .AE_LEVEL   (2),
      .FWFT       (1'b1)
   ) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .wren_i      (wren),
      .wdata_i     (wdata),
      .rden_i      (rden),
      .clr_err_i   (clr_err),
      .rdata_o     (rdata1),
      .full_o      (full1),
      .empty_o     (empty1),
      .afull_o     (afull1),
      .aempty_o    (aempty1),
      .count_o     (count1),
      .overflow_o  (ovf1),
      .underflow_o (ufl1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: FIFO contents as a queue.
   logic [7:0] m_q[$];
   logic [7:0] m_rd0;
   logic       m_ovf;
   logic       m_ufl;
   bit         m_full;
   bit         m_empty;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_rd0 = 8'h00;
         m_ovf = 1'b0;
         m_ufl = 1'b0;
      end else begin
         m_full  = (m_q.size() == DEPTH);
         m_empty = (m_q.size() == 0);
         if (wren && m_full) m_ovf = 1'b1;
         else if (clr_err) m_ovf = 1'b0;
         if (rden && m_empty) m_ufl = 1'b1;
         else if (clr_err) m_ufl = 1'b0;
         if (rden && !m_empty) m_rd0 = m_q.pop_front();
         if (wren && !m_full) m_q.push_back(wdata);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         int n;
         n = m_q.size();
         chk("count0", 32'(count0), 32'(n));
         chk("count1", 32'(count1), 32'(n));
         chk("full0", 32'(full0), 32'(n == DEPTH));
         chk("full1", 32'(full1), 32'(n == DEPTH));
         chk("empty0", 32'(empty0), 32'(n == 0));
         chk("empty1", 32'(empty1), 32'(n == 0));
         chk("afull0", 32'(afull0), 32'(n >= 6));
         chk("afull1", 32'(afull1), 32'(n >= 6));
         chk("aempty0", 32'(aempty0), 32'(n <= 2));
         chk("aempty1", 32'(aempty1), 32'(n <= 2));
         chk("ovf0", 32'(ovf0), 32'(m_ovf));
         chk("ovf1", 32'(ovf1), 32'(m_ovf));
         chk("ufl0", 32'(ufl0), 32'(m_ufl));
         chk("ufl1", 32'(ufl1), 32'(m_ufl));
         chk("rdata0", 32'(rdata0), 32'(m_rd0));
         if (n != 0) chk("rdata1", 32'(rdata1), 32'(m_q[0]));
      end
   end

   task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
      wren    = wr;
      wdata   = wd;
      rden    = rd;
      clr_err = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_count0"}, 32'(count0), 32'd0);
      chk({tag, "_count1"}, 32'(count1), 32'd0);
      chk({tag, "_empty0"}, 32'(empty0), 32'd1);
      chk({tag, "_empty1"}, 32'(empty1), 32'd1);
      chk({tag, "_aempty0"}, 32'(aempty0), 32'd1);
      chk({tag, "_full0"}, 32'(full0), 32'd0);
      chk({tag, "_afull0"}, 32'(afull0), 32'd0);
      chk({tag, "_ovf0"}, 32'(ovf0), 32'd0);
      chk({tag, "_ufl0"}, 32'(ufl0), 32'd0);
      chk({tag, "_ovf1"}, 32'(ovf1), 32'd0);
      chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      wren    = 1'b0;
      wdata   = 8'h00;
      rden    = 1'b0;
      clr_err = 1'b0;
      #3;
      chk_reset("por");
      #9;
      rst_n = 1'b1;

      // Fill 0..7 and watch the threshold flags move.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         chk("fill_count", 32'(count0), 32'(i + 1));
         if (i == 1) chk("aempty_at2", 32'(aempty0), 32'd1);
         if (i == 2) chk("aempty_at3", 32'(aempty0), 32'd0);
         if (i == 4) chk("afull_at5", 32'(afull0), 32'd0);
         if (i == 5) chk("afull_at6", 32'(afull0), 32'd1);
         if (i == 6) chk("full_at7", 32'(full0), 32'd0);
         if (i == 7) chk("full_at8", 32'(full0), 32'd1);
      end
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_9th", 32'(ovf0), 32'd1);
      chk("count_9th", 32'(count0), 32'd8);

      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_rdata", 32'(rdata0), 32'(i));
      end
      chk("drain_empty", 32'(empty0), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ufl_extra", 32'(ufl0), 32'd1);
      chk("rdata_hold", 32'(rdata0), 32'h07);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", 32'(ovf0), 32'd0);
      chk("clr_ufl", 32'(ufl0), 32'd0);

      // Streaming across pointer wrap.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
         chk("stream_count", 32'(count0), 32'd4);
         if (i == 0) chk("stream_first", 32'(rdata0), 32'h40);
         if (i == 4) chk("stream_fifth", 32'(rdata0), 32'h50);
      end

      // Simultaneous read/write at full.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      chk("refill_full", 32'(full0), 32'd1);
      step(1'b1, 8'hEE, 1'b1, 1'b0);
      chk("rw_full_count", 32'(count0), 32'd7);
      chk("rw_full_ovf", 32'(ovf0), 32'd1);
      chk("rw_full_rdata", 32'(rdata0), 32'h58);

      // Simultaneous read/write at empty.
      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain2_empty", 32'(empty0), 32'd1);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("rw_empty_count", 32'(count0), 32'd1);
      chk("rw_empty_ufl", 32'(ufl0), 32'd1);
      chk("rw_empty_hold", 32'(rdata0), 32'h63);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // FWFT show-ahead.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step(1'b1, 8'h11, 1'b0, 1'b0);
      chk("fwft_empty", 32'(empty1), 32'd0);
      chk("fwft_first", 32'(rdata1), 32'h11);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      chk("fwft_still_first", 32'(rdata1), 32'h11);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fwft_second", 32'(rdata1), 32'h22);
      chk("fwft_count", 32'(count1), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset mid-operation at count 5 with overflow set.
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step(1'b1, 8'hAB, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", 32'(count0), 32'd5);
      chk("pre_rst_ovf", 32'(ovf0), 32'd1);
      wren = 1'b0;
      rden = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      #1;
      rst_n = 1'b1;
      step(1'b1, 8'h33, 1'b0, 1'b0);
      chk("post_rst_fwft", 32'(rdata1), 32'h33);
      chk("post_rst_count", 32'(count0), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_read", 32'(rdata0), 32'h33);

      // Randomised traffic, alternating fill-biased and drain-biased phases.
      for (int n = 0; n < 800; n++) begin
         int wb;
         wb = ((n / 100) % 2 == 0) ? 70 : 30;
         step($urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) < (100 - wb),
              $urandom_range(0, 19) == 0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
